// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared data-memory port.
// slave: the arbiter side; master: requesters plus memory.
interface dmem_port_arbiter_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [N-1:0]  wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [N-1:0]  rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [N-1:0]  wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [N-1:0]  rdata1;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata;
  logic          busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    output mem_read, mem_write, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    input  mem_read, mem_write, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core load/store
// path (0) and the program/debug loader (1); one transaction in flight at a time.
module dmem_port_arbiter #(
  parameter int unsigned N      = 32,
  parameter int unsigned AW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);
  localparam int unsigned   CW      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CntLast = CW'(RD_LAT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StWaitRd} state_e;

  state_e        state_q, state_d;
  logic          last_q, owner_q, we_q;
  logic [AW-1:0] addr_q;
  logic [N-1:0]  wdata_q, rdata0_q, rdata1_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rvalid0_q, rvalid1_q;
  logic          pick, capture, rd_done;

  // Under contention the side that did not win last time goes next.
  assign pick = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    capture = 1'b0;
    rd_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          capture = 1'b1;
          state_d = StAccess;
        end
      end
      StAccess: state_d = we_q ? StIdle : StWaitRd;
      StWaitRd: begin
        if (cnt_q == CntLast) begin
          rd_done = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rd_done && !owner_q;
      rvalid1_q <= rd_done && owner_q;
      if (capture) begin
        owner_q <= pick;
        last_q  <= pick;
        we_q    <= pick ? bus.we1 : bus.we0;
        addr_q  <= pick ? bus.addr1 : bus.addr0;
        wdata_q <= pick ? bus.wdata1 : bus.wdata0;
      end
      if (rd_done && !owner_q) rdata0_q <= bus.mem_rdata;
      if (rd_done && owner_q)  rdata1_q <= bus.mem_rdata;
    end
  end

  assign bus.gnt0      = (state_q == StAccess) && !owner_q;
  assign bus.gnt1      = (state_q == StAccess) && owner_q;
  assign bus.mem_write = (state_q == StAccess) && we_q;
  assign bus.mem_read  = (state_q == StAccess) && !we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: instance a uses RD_LAT=1, instance b uses RD_LAT=3; each has
// a small memory model whose read data is valid only RD_LAT cycles after mem_read.
module tb_dmem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.N(32), .AW(32)) ifa ();
  dmem_port_arbiter_if #(.N(32), .AW(32)) ifb ();

  dmem_port_arbiter #(.N(32), .AW(32), .RD_LAT(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  dmem_port_arbiter #(.N(32), .AW(32), .RD_LAT(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // Memory a: writable, preset to C0DE_00xx, one-cycle read pipeline.
  logic [31:0] mem_a [256];
  logic [31:0] rd_a;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 32'hC0DE_0000 | 32'(i);
      rd_a <= 32'hBAD0_BAD0;
    end else begin
      if (ifa.mem_write) mem_a[ifa.mem_addr[7:0]] <= ifa.mem_wdata;
      rd_a <= ifa.mem_read ? mem_a[ifa.mem_addr[7:0]] : 32'hBAD0_BAD0;
    end
  end
  assign ifa.mem_rdata = rd_a;

  // Memory b: read-only, three-cycle read pipeline.
  logic [31:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_b[0] <= ifb.mem_read ? {16'hC0DE, ifb.mem_addr[15:0]} : 32'hBAD0_BAD0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign ifb.mem_rdata = pipe_b[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("excl_a", 32'({ifa.gnt0 & ifa.gnt1, ifa.rvalid0 & ifa.rvalid1,
                      ifa.mem_read & ifa.mem_write}), 0);
    chk("excl_b", 32'({ifb.gnt0 & ifb.gnt1, ifb.rvalid0 & ifb.rvalid1,
                      ifb.mem_read & ifb.mem_write}), 0);
  endtask

  initial begin
    reset = 1'b1;
    ifa.req0 = 0; ifa.we0 = 0; ifa.addr0 = '0; ifa.wdata0 = '0;
    ifa.req1 = 0; ifa.we1 = 0; ifa.addr1 = '0; ifa.wdata1 = '0;
    ifb.req0 = 0; ifb.we0 = 0; ifb.addr0 = '0; ifb.wdata0 = '0;
    ifb.req1 = 0; ifb.we1 = 0; ifb.addr1 = '0; ifb.wdata1 = '0;
    tick();
    tick();
    chk("rst_busy", 32'(ifa.busy), 0);
    chk("rst_gnt_rvalid", 32'({ifa.gnt0, ifa.gnt1, ifa.rvalid0, ifa.rvalid1}), 0);
    chk("rst_strobes", 32'({ifa.mem_read, ifa.mem_write}), 0);
    chk("rst_mem_addr", ifa.mem_addr, 0);
    chk("rst_mem_wdata", ifa.mem_wdata, 0);
    chk("rst_rdata0", ifa.rdata0, 0);
    chk("rst_rdata1", ifa.rdata1, 0);
    reset = 1'b0;

    // 1: async reset mid-ACCESS, then first contention goes to requester 0
    ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 32'h20;
    tick();
    chk("t1_gnt0", 32'(ifa.gnt0), 1);
    chk("t1_mem_addr", ifa.mem_addr, 32'h20);
    #3 reset = 1'b1;
    #1;
    chk("t1_async_outs", 32'({ifa.busy, ifa.gnt0, ifa.mem_read}), 0);
    chk("t1_async_addr", ifa.mem_addr, 0);
    tick();
    ifa.req0 = 0;
    reset = 1'b0;
    ifa.req0 = 1; ifa.we0 = 1; ifa.addr0 = 32'h30; ifa.wdata0 = 32'h1111_0000;
    ifa.req1 = 1; ifa.we1 = 1; ifa.addr1 = 32'h31; ifa.wdata1 = 32'h2222_0000;
    tick();
    chk("t1_first_gnt", 32'({ifa.gnt0, ifa.gnt1}), 32'b10);
    chk("t1_first_addr", ifa.mem_addr, 32'h30);
    ifa.req0 = 0;
    tick();
    chk("t1_idle", 32'({ifa.busy, ifa.gnt1}), 0);
    tick();
    chk("t1_second_gnt", 32'({ifa.gnt0, ifa.gnt1, ifa.mem_write}), 32'b011);
    chk("t1_second_wdata", ifa.mem_wdata, 32'h2222_0000);
    ifa.req1 = 0;
    tick();
    chk("t1_back_idle", 32'(ifa.busy), 0);

    // 2: write 0x10 then read it back
    ifa.req0 = 1; ifa.we0 = 1; ifa.addr0 = 32'h10; ifa.wdata0 = 32'hDEAD_BEEF;
    tick();
    chk("t2_wr_gnt0", 32'({ifa.gnt0, ifa.busy}), 32'b11);
    chk("t2_wr_strobes", 32'({ifa.mem_write, ifa.mem_read}), 32'b10);
    chk("t2_wr_addr", ifa.mem_addr, 32'h10);
    chk("t2_wr_wdata", ifa.mem_wdata, 32'hDEAD_BEEF);
    ifa.req0 = 0;
    tick();
    chk("t2_wr_done", 32'({ifa.busy, ifa.gnt0, ifa.mem_write}), 0);
    ifa.req0 = 1; ifa.we0 = 0;
    tick();
    chk("t2_rd_gnt0", 32'({ifa.gnt0, ifa.mem_write, ifa.mem_read}), 32'b101);
    ifa.req0 = 0;
    tick();
    chk("t2_rd_wait", 32'({ifa.busy, ifa.rvalid0, ifa.gnt0, ifa.mem_read}), 32'b1000);
    tick();
    chk("t2_rvalid0", 32'({ifa.rvalid0, ifa.rvalid1, ifa.busy}), 32'b100);
    chk("t2_rdata0", ifa.rdata0, 32'hDEAD_BEEF);
    tick();
    chk("t2_rvalid0_pulse", 32'(ifa.rvalid0), 0);
    chk("t2_rdata0_hold", ifa.rdata0, 32'hDEAD_BEEF);

    // 3: both reading continuously; last grant was 0 so requester 1 leads
    ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 32'h20;
    ifa.req1 = 1; ifa.we1 = 0; ifa.addr1 = 32'h40;
    for (int k = 0; k < 4; k++) begin
      logic own;
      own = (k % 2 == 0);
      tick();
      chk("t3_gnt", 32'({ifa.gnt0, ifa.gnt1}), own ? 32'b01 : 32'b10);
      chk("t3_addr", ifa.mem_addr, own ? 32'h40 : 32'h20);
      tick();
      chk("t3_wait", 32'({ifa.gnt0, ifa.gnt1, ifa.mem_read, ifa.mem_write}), 0);
      if (k == 3) begin
        ifa.req0 = 0;
        ifa.req1 = 0;
      end
      tick();
      chk("t3_rvalid", 32'({ifa.rvalid0, ifa.rvalid1}), own ? 32'b01 : 32'b10);
      chk("t3_rdata", own ? ifa.rdata1 : ifa.rdata0, own ? 32'hC0DE_0040 : 32'hC0DE_0020);
    end

    // 6: a one-cycle req1 while busy is never sampled
    ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 32'h20;
    tick();
    chk("t6_gnt0", 32'(ifa.gnt0), 1);
    ifa.req0 = 0;
    ifa.req1 = 1; ifa.we1 = 1; ifa.addr1 = 32'h55; ifa.wdata1 = 32'h5555_5555;
    tick();
    ifa.req1 = 0;
    chk("t6_wait", 32'({ifa.gnt1, ifa.mem_write}), 0);
    tick();
    chk("t6_rvalid0", 32'(ifa.rvalid0), 1);
    tick();
    chk("t6_no_gnt1", 32'({ifa.gnt1, ifa.mem_write, ifa.busy}), 0);
    tick();
    chk("t6_still_idle", 32'({ifa.gnt1, ifa.mem_write, ifa.busy}), 0);
    chk("t6_mem55", mem_a[8'h55], 32'hC0DE_0055);

    // 5: reset in WAIT_RD aborts the read
    ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 32'h20;
    tick();
    ifa.req0 = 0;
    tick();
    chk("t5_wait_busy", 32'(ifa.busy), 1);
    #3 reset = 1'b1;
    #1;
    chk("t5_abort", 32'({ifa.busy, ifa.rvalid0}), 0);
    chk("t5_rdata0", ifa.rdata0, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t5_no_rvalid", 32'({ifa.rvalid0, ifa.busy}), 0);
    ifa.req0 = 1; ifa.addr0 = 32'h40;
    tick();
    chk("t5_gnt0", 32'(ifa.gnt0), 1);
    ifa.req0 = 0;
    tick();
    tick();
    chk("t5_rvalid0", 32'(ifa.rvalid0), 1);
    chk("t5_rdata0_new", ifa.rdata0, 32'hC0DE_0040);

    // 4: RD_LAT=3, requester 1 read; req0 arriving in WAIT_RD waits for rvalid1
    ifb.req1 = 1; ifb.we1 = 0; ifb.addr1 = 32'h40;
    tick();
    chk("t4_gnt1", 32'({ifb.gnt0, ifb.gnt1, ifb.mem_read}), 32'b011);
    ifb.req1 = 0;
    tick();
    ifb.req0 = 1; ifb.we0 = 0; ifb.addr0 = 32'h20;
    tick();
    chk("t4_wait3", 32'({ifb.gnt0, ifb.rvalid1, ifb.busy}), 32'b001);
    tick();
    chk("t4_wait4", 32'({ifb.gnt0, ifb.rvalid1, ifb.busy}), 32'b001);
    tick();
    chk("t4_rvalid1", 32'({ifb.gnt0, ifb.rvalid1, ifb.busy}), 32'b010);
    chk("t4_rdata1", ifb.rdata1, 32'hC0DE_0040);
    tick();
    chk("t4_gnt0_after", 32'({ifb.gnt0, ifb.gnt1, ifb.mem_read}), 32'b101);
    ifb.req0 = 0;
    tick();
    tick();
    tick();
    chk("t4_rvalid0_early", 32'(ifb.rvalid0), 0);
    tick();
    chk("t4_rvalid0", 32'(ifb.rvalid0), 1);
    chk("t4_rdata0", ifb.rdata0, 32'hC0DE_0020);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (mem_read, mem_write, address, write data, read data) between two requesters.
- Requester 0 is the core load/store path. Requester 1 is the program/debug loader.
- Arbitration is round-robin with a valid/grant handshake. Exactly one memory transaction is in flight at any time.
- Read data returns with a fixed, parameterised memory latency and is routed back to the requester that issued the read.

Parameters:
- N, 32: data width of all data buses.
- AW, 32: address width.
- RD_LAT, 1: cycles from the mem_read strobe to valid mem_rdata. Legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 transaction request.
- we0  in  1  requester 0 write (1) / read (0).
- addr0  in  AW  requester 0 address.
- wdata0  in  N  requester 0 write data.
- gnt0  out  1  one-cycle pulse: requester 0 transaction accepted.
- rvalid0  out  1  one-cycle pulse: rdata0 valid.
- rdata0  out  N  requester 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same meanings for requester 1.
- mem_read  out  1  read strobe to the data memory.
- mem_write  out  1  write strobe to the data memory.
- mem_addr  out  AW  memory address.
- mem_wdata  out  N  memory write data.
- mem_rdata  in  N  memory read data, valid RD_LAT cycles after mem_read.
- busy  out  1  high in any state other than IDLE.

Behaviour:

Reset:
- Reset is asynchronous and active-high.
- On assertion, every output goes to 0 immediately: gnt*, rvalid*, rdata*, mem_*, busy.
- The FSM goes to IDLE, last_gnt goes to 1 (so requester 0 wins the first contention), and the latency counter goes to 0.
- Reset mid-transaction aborts it. No rvalid or gnt is produced for the aborted transaction.

FSM states: IDLE, ACCESS, WAIT_RD.

IDLE:
- Sample req0 and req1.
  - Only one asserted: select it.
  - Both asserted: select the one not equal to last_grant.
  - Neither asserted: stay in IDLE.
- On selection, register we/addr/wdata from the winner into the mem_* outputs, set last_gnt to the winner, and go to ACCESS.

ACCESS (exactly one cycle):
- mem_write = captured we, mem_read = !captured we. Only one strobe is high.
- gnt of the selected requester is 1 for this cycle only.
- Next state: WAIT_RD for a read, IDLE for a write.
- On leaving ACCESS, both strobes drop to 0. mem_addr and mem_wdata hold their values until the next ACCESS.

WAIT_RD:
- The counter counts RD_LAT cycles, starting with the cycle after the mem_read strobe.
- In the cycle where mem_rdata becomes valid (RD_LAT cycles after the strobe):
  - capture mem_rdata into rdata of the owning requester;
  - pulse that requester's rvalid the following cycle;
  - return to IDLE in that same cycle.
- rdata of the other requester is unchanged. rdataX holds its last value between reads.

Timing:
- Write: request seen in IDLE at cycle t, mem_write and gnt at t+1, next arbitration at t+2.
- Read: request at t, mem_read and gnt at t+1, rvalid at t+2+RD_LAT, next arbitration at t+2+RD_LAT.
- An arbitration decision made in IDLE while rvalid is pulsing is legal.

Requester rules:
- A requester holds req, we, addr and wdata stable from assertion until it sees gnt.
- Dropping req before the arbiter samples it in IDLE cancels the request with no side effect.
- Once captured in IDLE, the transaction completes even if req drops.

Fairness:
- Back-to-back contention alternates grants: 0, 1, 0, 1, ...
- A single continuous requester is granted every transaction slot.

Invariants:
- gnt0 and gnt1 are never both high.
- rvalid0 and rvalid1 are never both high.
- mem_read and mem_write are never both high.
- No gnt or strobe occurs in WAIT_RD.
- Addresses and data pass through unmodified. There is no width conversion or alignment checking.

Test Plan:
1. Reset check: assert reset mid-cycle with req0 held -> all outputs 0 asynchronously. After deassert, IDLE; the first grant is gnt0.
2. Requester-0 write addr 0x10, data 0xDEADBEEF, RD_LAT=1 -> mem_write=1 and gnt0=1 one cycle after the request; busy high for 1 cycle; then a read of 0x10 returns rdata0=0xDEADBEEF with rvalid0 exactly 3 cycles after the request.
3. Both requesters reading continuously (addr0=0x20, addr1=0x40) -> grant order 0,1,0,1. rdata0 always carries the mem[0x20] value and rdata1 the mem[0x40] value; rvalid0 and rvalid1 are never both high.
4. RD_LAT=3 build: requester-1 read -> rvalid1 5 cycles after the request. A req0 arriving during WAIT_RD is not granted until after rvalid1.
5. Reset asserted in WAIT_RD during a requester-0 read -> no rvalid0. rdata0 = 0, the FSM is in IDLE, and a subsequent request is served normally.
6. req1 pulsed for 1 cycle while a requester-0 transaction is busy (not sampled in IDLE) -> no gnt1 and no memory access for requester 1.
